// File: rtl/eth_frame_byte_tx_if.sv
// ---------------------------------------------------------------------------
// eth_frame_byte_tx_if
//   Bundles the signals of the frame byte transmitter:
//   - word channel (i_word_vld / o_word_rdy / i_word / i_word_last /
//     i_word_last_nbytes) carrying 32-bit frame words, MSB byte first
//   - i_afull back-pressure from the receiver's CDC FIFO
//   - byte link (o_byte_vld / o_last_byte / o_byte_parity / o_byte)
//   Signal names keep the transmitter's point of view (i_ = into it).
//   slave  : the transmitter's view
//   master : the environment's view (word source + byte sink)
// ---------------------------------------------------------------------------
interface eth_frame_byte_tx_if;
    logic        i_word_vld;
    logic        o_word_rdy;
    logic [31:0] i_word;
    logic        i_word_last;
    logic [1:0]  i_word_last_nbytes;
    logic        i_afull;
    logic        o_byte_vld;
    logic        o_last_byte;
    logic        o_byte_parity;
    logic [7:0]  o_byte;

    modport slave (
        input  i_word_vld, i_word, i_word_last, i_word_last_nbytes, i_afull,
        output o_word_rdy, o_byte_vld, o_last_byte, o_byte_parity, o_byte
    );

    modport master (
        output i_word_vld, i_word, i_word_last, i_word_last_nbytes, i_afull,
        input  o_word_rdy, o_byte_vld, o_last_byte, o_byte_parity, o_byte
    );
endinterface

// File: rtl/eth_frame_byte_tx.sv
// ---------------------------------------------------------------------------
// eth_frame_byte_tx
//   Serializes 32-bit frame words into a parity-protected byte stream.
//   Frames shorter than MIN_FRAME_BYTES are padded with 0x00, frames longer
//   than MAX_FRAME_BYTES are cut at MAX_FRAME_BYTES (the rest of the frame
//   is swallowed), and emission pauses while the registered almost-full
//   from the receiver is set.
//
// Ports
//   i_sys_clk          : sole clock, rising edge
//   i_sys_clk_arst_n   : asynchronous active-low reset
//   bus (slave)        : word channel, i_afull and byte link
//   o_busy             : state is not IDLE
//   o_frames_sent      : frames whose last byte has been emitted (wraps)
//   o_frames_truncated : frames cut at MAX_FRAME_BYTES (wraps)
// ---------------------------------------------------------------------------
module eth_frame_byte_tx #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 1514
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_clk_arst_n,
    eth_frame_byte_tx_if.slave   bus,
    output logic                 o_busy,
    output logic [31:0]          o_frames_sent,
    output logic [15:0]          o_frames_truncated
);

    localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_PAD,
        ST_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Single word buffer; r_buf_lastidx is the index of its final valid byte.
    logic [31:0] r_buf;
    logic        r_buf_vld;
    logic        r_buf_last;
    logic [1:0]  r_buf_lastidx;
    logic [1:0]  r_byte_idx;

    logic [10:0] r_byte_cnt;
    logic        r_afull_q;

    logic        r_byte_vld;
    logic        r_last_byte;
    logic        r_byte_parity;
    logic [7:0]  r_byte;
    logic [31:0] r_frames_sent;
    logic [15:0] r_frames_trunc;

    logic [7:0]  w_cur_byte;
    logic        w_buf_final;
    logic [10:0] w_cnt_inc;

    logic        w_word_rdy;
    logic        w_emit;
    logic [7:0]  w_emit_byte;
    logic        w_emit_last;
    logic        w_load;
    logic        w_pop;
    logic        w_adv;
    logic        w_cnt_clr;
    logic        w_sent_inc;
    logic        w_trunc_inc;

    // Byte 0 of the word lives in bits [31:24].
    assign w_cur_byte  = r_buf[{~r_byte_idx, 3'b000} +: 8];
    assign w_buf_final = (r_byte_idx == r_buf_lastidx);
    assign w_cnt_inc   = r_byte_cnt + 11'd1;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_word_rdy  = 1'b0;
        w_emit      = 1'b0;
        w_emit_byte = w_cur_byte;
        w_emit_last = 1'b0;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_adv       = 1'b0;
        w_cnt_clr   = 1'b0;
        w_sent_inc  = 1'b0;
        w_trunc_inc = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_word_rdy = 1'b1;
                if (bus.i_word_vld) begin
                    w_load      = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end

            ST_SEND: begin
                if (!r_buf_vld) begin
                    w_word_rdy = 1'b1;
                    w_load     = bus.i_word_vld;
                end else if (!r_afull_q) begin
                    w_emit = 1'b1;
                    if (w_buf_final) begin
                        w_pop      = 1'b1;
                        w_word_rdy = 1'b1;
                    end else begin
                        w_adv = 1'b1;
                    end

                    if (w_buf_final && r_buf_last) begin
                        // Last data byte. A word taken now already belongs
                        // to the next frame; it waits in the buffer
                        // through any padding.
                        w_load = bus.i_word_vld;
                        if (w_cnt_inc < MIN_CNT) begin
                            w_state_nxt = ST_PAD;
                        end else begin
                            w_emit_last = 1'b1;
                            w_sent_inc  = 1'b1;
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = bus.i_word_vld ? ST_SEND : ST_IDLE;
                        end
                    end else if (w_cnt_inc == MAX_CNT) begin
                        // Truncation: the rest of the buffer is dropped, and
                        // a word taken now is part of this frame's tail.
                        w_emit_last = 1'b1;
                        w_sent_inc  = 1'b1;
                        w_trunc_inc = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_pop       = 1'b1;
                        w_adv       = 1'b0;
                        if (r_buf_last || (w_word_rdy && bus.i_word_vld && bus.i_word_last))
                            w_state_nxt = ST_IDLE;
                        else
                            w_state_nxt = ST_DRAIN;
                    end else begin
                        w_load = w_word_rdy & bus.i_word_vld;
                    end
                end
            end

            ST_PAD: begin
                if (!r_afull_q) begin
                    w_emit      = 1'b1;
                    w_emit_byte = 8'h00;
                    if (w_cnt_inc >= MIN_CNT) begin
                        w_emit_last = 1'b1;
                        w_sent_inc  = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = r_buf_vld ? ST_SEND : ST_IDLE;
                    end
                end
            end

            ST_DRAIN: begin
                w_word_rdy = 1'b1;
                if (bus.i_word_vld && bus.i_word_last)
                    w_state_nxt = ST_IDLE;
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge i_sys_clk or negedge i_sys_clk_arst_n) begin
        if (!i_sys_clk_arst_n) begin
            r_state        <= ST_IDLE;
            r_buf_vld      <= 1'b0;
            r_buf_last     <= 1'b0;
            r_buf_lastidx  <= 2'd0;
            r_byte_idx     <= 2'd0;
            r_byte_cnt     <= 11'd0;
            r_afull_q      <= 1'b1;
            r_byte_vld     <= 1'b0;
            r_last_byte    <= 1'b0;
            r_byte_parity  <= 1'b0;
            r_byte         <= 8'h00;
            r_frames_sent  <= 32'd0;
            r_frames_trunc <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_afull_q <= bus.i_afull;

            if (w_load) begin
                r_buf_vld     <= 1'b1;
                r_buf_last    <= bus.i_word_last;
                r_buf_lastidx <= bus.i_word_last ? (bus.i_word_last_nbytes - 2'd1) : 2'd3;
                r_byte_idx    <= 2'd0;
            end else if (w_pop) begin
                r_buf_vld <= 1'b0;
            end else if (w_adv) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end

            if (w_cnt_clr)
                r_byte_cnt <= 11'd0;
            else if (w_emit)
                r_byte_cnt <= w_cnt_inc;

            r_byte_vld  <= w_emit;
            r_last_byte <= w_emit_last;
            if (w_emit) begin
                r_byte        <= w_emit_byte;
                r_byte_parity <= ^w_emit_byte;
            end

            if (w_sent_inc)
                r_frames_sent <= r_frames_sent + 32'd1;
            if (w_trunc_inc)
                r_frames_trunc <= r_frames_trunc + 16'd1;
        end
    end

    // NOTE: buffer data needs no reset because r_buf_vld gates every use of it; only control state is reset.
    always_ff @(posedge i_sys_clk) begin
        if (w_load)
            r_buf <= bus.i_word;
    end

    // Gated with reset so the handshake also reads 0 while reset is held.
    assign bus.o_word_rdy    = w_word_rdy & i_sys_clk_arst_n;
    assign bus.o_byte_vld    = r_byte_vld;
    assign bus.o_last_byte   = r_last_byte;
    assign bus.o_byte_parity = r_byte_parity;
    assign bus.o_byte        = r_byte;

    assign o_busy             = (r_state != ST_IDLE);
    assign o_frames_sent      = r_frames_sent;
    assign o_frames_truncated = r_frames_trunc;

endmodule

// File: tb/tb_eth_frame_byte_tx.sv
// ---------------------------------------------------------------------------
// tb_eth_frame_byte_tx
//   Directed bench for eth_frame_byte_tx. Each frame is described by its
//   length and first byte value; the model expands that into the byte list
//   the link must carry (pad to MIN, cut at MAX) and a compare process
//   checks every emitted byte, flag and parity against it. Frame counters
//   and byte totals are checked against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_eth_frame_byte_tx;

    localparam int MIN_B = 60;
    localparam int MAX_B = 1514;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_frame_byte_tx_if bus ();

    logic        busy;
    logic [31:0] frames_sent;
    logic [15:0] frames_trunc;

    eth_frame_byte_tx #(
        .MIN_FRAME_BYTES (MIN_B),
        .MAX_FRAME_BYTES (MAX_B)
    ) dut (
        .i_sys_clk          (clk),
        .i_sys_clk_arst_n   (rst_n),
        .bus                (bus),
        .o_busy             (busy),
        .o_frames_sent      (frames_sent),
        .o_frames_truncated (frames_trunc)
    );

    typedef struct {
        logic [7:0] b;
        logic       last;
        logic       pad;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   seen_bytes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected link content for one frame, straight from the framing rules.
    task automatic model_frame(input int nbytes, input int first);
        int out_len;
        exp_t e;
        out_len = (nbytes < MIN_B) ? MIN_B : ((nbytes > MAX_B) ? MAX_B : nbytes);
        for (int i = 0; i < out_len; i++) begin
            e.pad  = (i >= nbytes);
            e.b    = e.pad ? 8'h00 : 8'((first + i) & 255);
            e.last = (i == out_len - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic put_word(input logic [31:0] w, input logic last, input logic [1:0] nb);
        int t;
        bus.i_word_vld         = 1'b1;
        bus.i_word             = w;
        bus.i_word_last        = last;
        bus.i_word_last_nbytes = nb;
        t = 0;
        while (bus.o_word_rdy !== 1'b1) begin
            @(negedge clk);
            t++;
            if (t > 2000) begin
                check("word_rdy_timeout", 32'(t), 32'd0);
                break;
            end
        end
        @(negedge clk);
    endtask

    // Sends a frame of nbytes bytes valued first, first+1, ...; bytes past
    // the end of the final word carry 0xEE, which must never appear.
    task automatic send_frame(input int nbytes, input int first, input int word_limit, input bit hold);
        int nw;
        logic [31:0] w;
        int idx;
        model_frame(nbytes, first);
        nw = (nbytes + 3) / 4;
        if (word_limit > 0 && word_limit < nw) nw = word_limit;
        for (int wi = 0; wi < nw; wi++) begin
            for (int k = 0; k < 4; k++) begin
                idx = wi * 4 + k;
                w[31 - 8*k -: 8] = (idx < nbytes) ? 8'((first + idx) & 255) : 8'hEE;
            end
            put_word(w, (wi == (nbytes + 3) / 4 - 1), 2'(nbytes % 4));
        end
        if (!hold) bus.i_word_vld = 1'b0;
    endtask

    task automatic drain();
        int t;
        bus.i_word_vld = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic afull_ctrl();
        int t;
        int extra;
        int late;
        t = 0;
        extra = 0;
        late = 0;
        while (!(bus.o_byte_vld === 1'b1 && bus.o_byte === 8'h53)) begin
            @(negedge clk);
            t++;
            if (t > 2000) begin
                check("afull_byte20_timeout", 32'(t), 32'd0);
                break;
            end
        end
        bus.i_afull = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.o_byte_vld) begin
                extra++;
                if (c >= 2) late++;
            end
        end
        bus.i_afull = 1'b0;
        check("afull_at_most_2_bytes", 32'(extra <= 2), 32'd1);
        check("afull_no_bytes_when_stalled", 32'(late), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_vld"}, 32'(bus.o_byte_vld), 32'd0);
        check({tag, "_last_byte"}, 32'(bus.o_last_byte), 32'd0);
        check({tag, "_parity"}, 32'(bus.o_byte_parity), 32'd0);
        check({tag, "_byte"}, 32'(bus.o_byte), 32'd0);
        check({tag, "_word_rdy"}, 32'(bus.o_word_rdy), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frames_sent"}, frames_sent, 32'd0);
        check({tag, "_frames_trunc"}, 32'(frames_trunc), 32'd0);
    endtask

    // Compare process: every emitted byte against the model.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.o_last_byte && !bus.o_byte_vld)
                check("last_without_vld", 32'(bus.o_last_byte), 32'd0);
            if (bus.o_byte_vld) begin
                seen_bytes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_value", 32'(bus.o_byte), 32'(e.b));
                    check("last_flag", 32'(bus.o_last_byte), 32'(e.last));
                    check("parity", 32'(bus.o_byte_parity), 32'(^e.b));
                    if (e.pad && !e.last)
                        check("word_rdy_in_pad", 32'(bus.o_word_rdy), 32'd0);
                end
            end
        end
    end

    initial begin
        int t;
        bus.i_word_vld         = 1'b0;
        bus.i_word             = 32'h0;
        bus.i_word_last        = 1'b0;
        bus.i_word_last_nbytes = 2'd0;
        bus.i_afull            = 1'b0;
        rst_n                  = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 64 bytes 0x00..0x3F, exactly 16 full words.
        seen_bytes = 0;
        send_frame(64, 8'h00, 0, 1'b0);
        drain();
        check("t1_bytes", 32'(seen_bytes), 32'd64);
        check("t1_frames_sent", frames_sent, 32'd1);
        check("t1_frames_trunc", 32'(frames_trunc), 32'd0);

        // 10-byte runt -> 10 data + 50 pad.
        seen_bytes = 0;
        send_frame(10, 8'hA0, 0, 1'b0);
        drain();
        check("t2_bytes", 32'(seen_bytes), 32'd60);
        check("t2_frames_sent", frames_sent, 32'd2);

        // 1600-byte frame cut at 1514, then an exact 1514-byte frame.
        seen_bytes = 0;
        send_frame(1600, 8'h00, 0, 1'b0);
        drain();
        check("t3_trunc_bytes", 32'(seen_bytes), 32'd1514);
        check("t3_frames_trunc", 32'(frames_trunc), 32'd1);
        check("t3_frames_sent", frames_sent, 32'd3);
        seen_bytes = 0;
        send_frame(1514, 8'h07, 0, 1'b0);
        drain();
        check("t3_max_bytes", 32'(seen_bytes), 32'd1514);
        check("t3_max_not_trunc", 32'(frames_trunc), 32'd1);
        check("t3_max_frames_sent", frames_sent, 32'd4);

        // Almost-full raised after byte 20 (value 0x53) for 50 cycles.
        seen_bytes = 0;
        fork
            send_frame(64, 8'h40, 0, 1'b0);
            afull_ctrl();
        join
        drain();
        check("t4_bytes", 32'(seen_bytes), 32'd64);
        check("t4_frames_sent", frames_sent, 32'd5);

        // Reset mid-frame once byte 30 (value 0x9D) is out.
        send_frame(64, 8'h80, 8, 1'b0);
        t = 0;
        while (!(bus.o_byte_vld === 1'b1 && bus.o_byte === 8'h9D)) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                check("t5_byte30_timeout", 32'(t), 32'd0);
                break;
            end
        end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("mid_frame_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        seen_bytes = 0;
        send_frame(64, 8'h10, 0, 1'b0);
        drain();
        check("t5_bytes", 32'(seen_bytes), 32'd64);
        check("t5_frames_sent", frames_sent, 32'd1);
        check("t5_frames_trunc", 32'(frames_trunc), 32'd0);

        // Three back-to-back 60-byte frames, valid never dropped between.
        seen_bytes = 0;
        send_frame(60, 8'h20, 0, 1'b1);
        send_frame(60, 8'h5C, 0, 1'b1);
        send_frame(60, 8'h98, 0, 1'b0);
        drain();
        check("t6_bytes", 32'(seen_bytes), 32'd180);
        check("t6_frames_sent", frames_sent, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eth_frame_byte_tx.md
ETH_FRAME_BYTE_TX -- requirements
Module: eth_frame_byte_tx

Purpose: upstream feeder of the inter-FPGA Ethernet frame byte link. Serializes 32-bit frame words into a parity-protected byte stream, pads runts, truncates oversize frames and throttles on the receiver's almost-full.

Interface
REQ-001 SHALL have parameter MIN_FRAME_BYTES, default 60, minimum emitted bytes per frame.
REQ-002 SHALL have parameter MAX_FRAME_BYTES, default 1514, maximum emitted bytes per frame.
REQ-003 SHALL have port i_sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_sys_clk_arst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_word_vld  input  1  input word valid.
REQ-006 SHALL have port o_word_rdy  output  1  input word accepted when i_word_vld & o_word_rdy.
REQ-007 SHALL have port i_word  input  32  frame data; bits [31:24] are sent first.
REQ-008 SHALL have port i_word_last  input  1  final word of frame.
REQ-009 SHALL have port i_word_last_nbytes  input  2  valid bytes in final word; 0 means 4; ignored when i_word_last=0.
REQ-010 SHALL have port i_afull  input  1  receiver CDC FIFO almost full.
REQ-011 SHALL have ports o_byte_vld (output, 1), o_last_byte (output, 1), o_byte_parity (output, 1) and o_byte (output, 8), forming the byte link.
REQ-012 SHALL have port o_busy  output  1  high when state is not IDLE.
REQ-013 SHALL have port o_frames_sent  output  32  count of frames whose last byte has been emitted.
REQ-014 SHALL have port o_frames_truncated  output  16  count of truncated frames.

Function
REQ-015 SHALL implement states IDLE, SEND, PAD and DRAIN.
REQ-016 SHALL move IDLE->SEND on the first accepted word; the byte counter (11 bits) SHALL be cleared at that point.
REQ-017 SHALL hold one word buffer; o_word_rdy SHALL be high in IDLE, and in SEND when the buffer is empty or its final valid byte is emitted this cycle; it SHALL be low in PAD.
REQ-018 SHALL register i_afull once (afull_q); a byte SHALL be emitted in a cycle only if afull_q=0, so at most 2 bytes follow an i_afull rise.
REQ-019 SHALL drive all byte-link outputs from registers; o_byte_vld is high for exactly one cycle per emitted byte.
REQ-020 SHALL set o_byte_parity = XOR of o_byte[7:0] (even parity over 9 bits).
REQ-021 SHALL assert o_last_byte only with o_byte_vld, on the final emitted byte of a frame.
REQ-022 SHALL, when the last data byte is at count < MIN_FRAME_BYTES, go SEND->PAD and emit 0x00 bytes until MIN_FRAME_BYTES total; o_last_byte SHALL go on the final pad byte.
REQ-023 SHALL, when data reaches MAX_FRAME_BYTES before the frame's last byte, flag o_last_byte on byte MAX_FRAME_BYTES, increment o_frames_truncated, and enter DRAIN.
REQ-024 SHALL, in DRAIN, hold o_word_rdy=1, discard words without emitting, and return to IDLE after accepting i_word_last.
REQ-025 SHALL treat a frame of exactly MIN_FRAME_BYTES as unpadded and exactly MAX_FRAME_BYTES as untruncated.
REQ-026 SHALL return to IDLE after the last byte of a frame; the next frame's first word MAY be accepted in that same cycle with no bubble required.
REQ-027 SHALL wrap both counters modulo 2^width; o_frames_sent SHALL increment for every frame ending with o_last_byte, including padded and truncated ones.
REQ-028 SHALL never emit a byte out of order, duplicated or dropped across afull stalls.

Reset
REQ-029 SHALL, while i_sys_clk_arst_n=0, immediately force state IDLE, word buffer empty, afull_q=1, all outputs 0 and both counters 0.
REQ-030 SHALL abandon any in-progress frame on reset, without emitting o_last_byte for it.

Verification
REQ-031 SHALL cover: 16 words 0x00010203..., last_nbytes=0, afull=0 -> 64 bytes 0x00..0x3F, last on byte 64, parity per byte correct, o_frames_sent=1.
REQ-032 SHALL cover: 3 words, last_nbytes=2 (10 bytes) -> 10 data bytes then 50 bytes 0x00, last on byte 60, o_word_rdy=0 during pad.
REQ-033 SHALL cover: 400-word frame (1600 bytes) -> 1514 bytes out, last on byte 1514, remaining 86 bytes accepted silently, o_frames_truncated=1; a following 1514-byte frame is not truncated.
REQ-034 SHALL cover: i_afull raised after byte 20 for 50 cycles -> at most 2 further bytes, then none; after release the stream resumes with byte 21/23 continuity, no loss or duplication.
REQ-035 SHALL cover: reset pulsed mid-frame at byte 30 -> outputs 0 asynchronously, counters 0; a subsequent 64-byte frame is sent intact.
REQ-036 SHALL cover: back-to-back 60-byte frames with i_word_vld held high -> no pad bytes, each frame's last_byte flagged, o_frames_sent increments per frame.
